hack_mmio_memory: RTL and testbench

- Parametrised successor to the single-port data/screen/keyboard memory.
- Provides a CPU port with registered reads, explicit read/write strobes and error reporting, a clean keyboard register, and an independent read-only video scan-out port into the screen region.
- Sits between the CPU and the display/keyboard controllers in the computer top level.

---
 rtl/hack_mem_pkg.sv | 39 +++
 rtl/hack_addr_decode.sv | 29 ++
 rtl/hack_mmio_memory.sv | 132 +++++++++++++
 tb/tb_hack_mmio_memory.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack MMIO memory: region encoding, default map
// constants and the address-to-region classifier.
package hack_mem_pkg;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_SCREEN,
    REG_KBD,
    REG_NONE
  } region_e;

  localparam int unsigned DefDataW       = 16;
  localparam int unsigned DefAddrW       = 16;
  localparam int unsigned DefRamDepth    = 16384;
  localparam int unsigned DefScreenBase  = 16384;
  localparam int unsigned DefScreenDepth = 8192;
  localparam int unsigned DefKbdAddr     = 24576;
  localparam int unsigned DefVidAddrW    = 13;

  // Address is zero-extended by the caller, so comparisons stay unsigned.
  function automatic region_e addr_region(input logic [31:0] addr,
                                          input int unsigned ram_depth,
                                          input int unsigned screen_base,
                                          input int unsigned screen_depth,
                                          input int unsigned kbd_addr);
    region_e r;
    if (addr < ram_depth) begin
      r = REG_RAM;
    end else if (addr >= screen_base && addr < screen_base + screen_depth) begin
      r = REG_SCREEN;
    end else if (addr == kbd_addr) begin
      r = REG_KBD;
    end else begin
      r = REG_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/hack_addr_decode.sv
// Combinational CPU address decoder: region plus local word index for the
// RAM and screen arrays.
module hack_addr_decode
  import hack_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = DefAddrW,
  parameter int unsigned RAM_DEPTH    = DefRamDepth,
  parameter int unsigned SCREEN_BASE  = DefScreenBase,
  parameter int unsigned SCREEN_DEPTH = DefScreenDepth,
  parameter int unsigned KBD_ADDR     = DefKbdAddr,
  parameter int unsigned VID_ADDR_W   = DefVidAddrW,
  parameter int unsigned RAM_IDX_W    = 14
) (
  input  logic [ADDR_W-1:0]     addr_i,
  output region_e               region_o,
  output logic [RAM_IDX_W-1:0]  ram_idx_o,
  output logic [VID_ADDR_W-1:0] scr_idx_o
);

  // Subtracting only the low bits equals the truncated full-width difference.
  localparam logic [VID_ADDR_W-1:0] ScrBaseLo = VID_ADDR_W'(SCREEN_BASE);

  always_comb begin
    region_o  = addr_region(32'(addr_i), RAM_DEPTH, SCREEN_BASE, SCREEN_DEPTH, KBD_ADDR);
    ram_idx_o = addr_i[RAM_IDX_W-1:0];
    scr_idx_o = addr_i[VID_ADDR_W-1:0] - ScrBaseLo;
  end

endmodule

// File: rtl/hack_mmio_memory.sv
// Hack data/screen/keyboard memory with registered CPU port, error pulses,
// synchronised keyboard register and an independent video read port.
module hack_mmio_memory
  import hack_mem_pkg::*;
#(
  parameter int unsigned DATA_W       = DefDataW,
  parameter int unsigned ADDR_W       = DefAddrW,
  parameter int unsigned RAM_DEPTH    = DefRamDepth,
  parameter int unsigned SCREEN_BASE  = DefScreenBase,
  parameter int unsigned SCREEN_DEPTH = DefScreenDepth,
  parameter int unsigned KBD_ADDR     = DefKbdAddr,
  parameter int unsigned VID_ADDR_W   = DefVidAddrW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic                  cpu_we,
  input  logic                  cpu_re,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_rvalid,
  output logic                  cpu_err,
  input  logic [DATA_W-1:0]     kbd_code,
  input  logic                  vid_req,
  input  logic [VID_ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0]     vid_rdata,
  output logic                  vid_rvalid
);

  localparam int unsigned RamIdxW = $clog2(RAM_DEPTH);

  region_e               region;
  logic [RamIdxW-1:0]    ram_idx;
  logic [VID_ADDR_W-1:0] scr_idx;

  hack_addr_decode #(
    .ADDR_W      (ADDR_W),
    .RAM_DEPTH   (RAM_DEPTH),
    .SCREEN_BASE (SCREEN_BASE),
    .SCREEN_DEPTH(SCREEN_DEPTH),
    .KBD_ADDR    (KBD_ADDR),
    .VID_ADDR_W  (VID_ADDR_W),
    .RAM_IDX_W   (RamIdxW)
  ) u_decode (
    .addr_i   (cpu_addr),
    .region_o (region),
    .ram_idx_o(ram_idx),
    .scr_idx_o(scr_idx)
  );

  logic [DATA_W-1:0] ram_mem [RAM_DEPTH];
  logic [DATA_W-1:0] scr_mem [SCREEN_DEPTH];

  logic [DATA_W-1:0] cpu_rdata_d, cpu_rdata_q;
  logic              cpu_rvalid_d, cpu_rvalid_q;
  logic              cpu_err_d, cpu_err_q;
  logic [DATA_W-1:0] vid_rdata_d, vid_rdata_q;
  logic              vid_rvalid_d, vid_rvalid_q;
  logic [DATA_W-1:0] kbd_meta_d, kbd_meta_q;
  logic [DATA_W-1:0] kbd_d, kbd_q;

  logic wr_ok, rd_ok, ram_wr, scr_wr, vid_in_range;

  assign wr_ok        = cpu_we & ~cpu_re;
  assign rd_ok        = cpu_re & ~cpu_we;
  assign ram_wr       = wr_ok && (region == REG_RAM);
  assign scr_wr       = wr_ok && (region == REG_SCREEN);
  assign vid_in_range = 32'(vid_addr) < SCREEN_DEPTH;

  // Arrays are not reset; nonblocking writes give read-old on a same-edge video read.
  always_ff @(posedge clk) begin
    if (ram_wr) ram_mem[ram_idx] <= cpu_wdata;
    if (scr_wr) scr_mem[scr_idx] <= cpu_wdata;
  end

  always_comb begin
    cpu_rdata_d  = cpu_rdata_q;
    cpu_rvalid_d = rd_ok;
    cpu_err_d    = 1'b0;
    kbd_meta_d   = kbd_code;
    kbd_d        = kbd_meta_q;

    if (cpu_we && cpu_re) begin
      cpu_err_d = 1'b1;
    end else if (cpu_we) begin
      cpu_err_d = (region == REG_KBD) || (region == REG_NONE);
    end else if (cpu_re) begin
      unique case (region)
        REG_RAM:    cpu_rdata_d = ram_mem[ram_idx];
        REG_SCREEN: cpu_rdata_d = scr_mem[scr_idx];
        REG_KBD:    cpu_rdata_d = kbd_q;
        REG_NONE: begin
          cpu_rdata_d = '0;
          cpu_err_d   = 1'b1;
        end
      endcase
    end

    vid_rvalid_d = vid_req;
    vid_rdata_d  = vid_rdata_q;
    if (vid_req) begin
      vid_rdata_d = vid_in_range ? scr_mem[vid_addr] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      cpu_err_q    <= 1'b0;
      vid_rdata_q  <= '0;
      vid_rvalid_q <= 1'b0;
      kbd_meta_q   <= '0;
      kbd_q        <= '0;
    end else begin
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_err_q    <= cpu_err_d;
      vid_rdata_q  <= vid_rdata_d;
      vid_rvalid_q <= vid_rvalid_d;
      kbd_meta_q   <= kbd_meta_d;
      kbd_q        <= kbd_d;
    end
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_err    = cpu_err_q;
  assign vid_rdata  = vid_rdata_q;
  assign vid_rvalid = vid_rvalid_q;

endmodule

// File: tb/tb_hack_mmio_memory.sv
// Directed table-driven bench for hack_mmio_memory with hand-written
// sequences for keyboard synchroniser timing and asynchronous reset.
module tb_hack_mmio_memory;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [15:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        cpu_err;
  logic [15:0] kbd_code;
  logic        vid_req;
  logic [12:0] vid_addr;
  logic [15:0] vid_rdata;
  logic        vid_rvalid;

  int checks;
  int failures;

  hack_mmio_memory dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_rdata (cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .cpu_err   (cpu_err),
    .kbd_code  (kbd_code),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_rdata (vid_rdata),
    .vid_rvalid(vid_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        vreq;
    logic [12:0] vaddr;
    logic [15:0] e_rdata;
    logic        e_rv;
    logic        e_err;
    logic [15:0] e_vdata;
    logic        e_vv;
  } vec_t;

  localparam int NumVec = 20;
  vec_t vecs[NumVec];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_we  = 1'b0;
    cpu_re  = 1'b0;
    vid_req = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //        we    re    addr       wdata     vreq  vaddr   e_rdata   rv    err   e_vdata   vv
    vecs[0]  = '{1'b0, 1'b1, 16'd24576, 16'h0000, 1'b0, 13'd0,    16'h0041, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 16'd100,   16'hBEEF, 1'b0, 13'd0,    16'h0041, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 16'd100,   16'h0000, 1'b0, 13'd0,    16'hBEEF, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 16'd16383, 16'h1234, 1'b0, 13'd0,    16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 16'd16383, 16'h0000, 1'b0, 13'd0,    16'h1234, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 16'd16384, 16'hAAAA, 1'b0, 13'd0,    16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 16'd0,     16'h0000, 1'b1, 13'd0,    16'h1234, 1'b0, 1'b0, 16'hAAAA, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 16'd16384, 16'h5555, 1'b1, 13'd0,    16'h1234, 1'b0, 1'b0, 16'hAAAA, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 16'd0,     16'h0000, 1'b1, 13'd0,    16'h1234, 1'b0, 1'b0, 16'h5555, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 16'd16384, 16'h0000, 1'b0, 13'd0,    16'h5555, 1'b1, 1'b0, 16'h5555, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 16'd24576, 16'h9999, 1'b0, 13'd0,    16'h5555, 1'b0, 1'b1, 16'h5555, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 16'd24576, 16'h0000, 1'b0, 13'd0,    16'h0041, 1'b1, 1'b0, 16'h5555, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 16'd30000, 16'h0000, 1'b0, 13'd0,    16'h0000, 1'b1, 1'b1, 16'h5555, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 16'd5,     16'h7777, 1'b0, 13'd0,    16'h0000, 1'b0, 1'b0, 16'h5555, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 16'd5,     16'h1111, 1'b0, 13'd0,    16'h0000, 1'b0, 1'b1, 16'h5555, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 16'd5,     16'h0000, 1'b0, 13'd0,    16'h7777, 1'b1, 1'b0, 16'h5555, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 16'd24575, 16'h0F0F, 1'b0, 13'd0,    16'h7777, 1'b0, 1'b0, 16'h5555, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 16'd24575, 16'h0000, 1'b1, 13'd8191, 16'h0F0F, 1'b1, 1'b0, 16'h0F0F, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 16'd24577, 16'h0000, 1'b0, 13'd0,    16'h0000, 1'b1, 1'b1, 16'h0F0F, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 16'd0,     16'h0000, 1'b0, 13'd0,    16'h0000, 1'b0, 1'b0, 16'h0F0F, 1'b0};

    // Reset with a key already present on the asynchronous input.
    rst_n     = 1'b0;
    kbd_code  = 16'h0041;
    cpu_addr  = '0;
    cpu_wdata = '0;
    vid_addr  = '0;
    idle_inputs();
    repeat (3) tick();
    chk("reset cpu_rdata", cpu_rdata, 16'h0000);
    chk("reset cpu_rvalid", 16'(cpu_rvalid), 16'h0000);
    chk("reset cpu_err", 16'(cpu_err), 16'h0000);
    chk("reset vid_rdata", vid_rdata, 16'h0000);
    chk("reset vid_rvalid", 16'(vid_rvalid), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < NumVec; i++) begin
      cpu_we    = vecs[i].we;
      cpu_re    = vecs[i].re;
      cpu_addr  = vecs[i].addr;
      cpu_wdata = vecs[i].wdata;
      vid_req   = vecs[i].vreq;
      vid_addr  = vecs[i].vaddr;
      tick();
      chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d cpu_rvalid", i), 16'(cpu_rvalid), 16'(vecs[i].e_rv));
      chk($sformatf("v%0d cpu_err", i), 16'(cpu_err), 16'(vecs[i].e_err));
      chk($sformatf("v%0d vid_rdata", i), vid_rdata, vecs[i].e_vdata);
      chk($sformatf("v%0d vid_rvalid", i), 16'(vid_rvalid), 16'(vecs[i].e_vv));
    end
    idle_inputs();

    // Keyboard synchroniser: reads at N and N+1 see the old value.
    kbd_code = 16'h0000;
    repeat (4) tick();
    cpu_re   = 1'b1;
    cpu_addr = 16'd24576;
    kbd_code = 16'h0080;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("kbd N+%0d rdata", k), cpu_rdata, (k < 2) ? 16'h0000 : 16'h0080);
      chk($sformatf("kbd N+%0d rvalid", k), 16'(cpu_rvalid), 16'h0001);
    end

    // Reset asserted between read strobe and the capturing edge.
    cpu_addr = 16'd100;
    #2;
    rst_n = 1'b0;
    tick();
    chk("mid-read reset rvalid", 16'(cpu_rvalid), 16'h0000);
    chk("mid-read reset rdata", cpu_rdata, 16'h0000);
    chk("mid-read reset err", 16'(cpu_err), 16'h0000);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post-reset idle rvalid", 16'(cpu_rvalid), 16'h0000);
    cpu_re   = 1'b1;
    cpu_addr = 16'd100;
    tick();
    chk("post-reset ram rdata", cpu_rdata, 16'hBEEF);
    chk("post-reset ram rvalid", 16'(cpu_rvalid), 16'h0001);
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
